usbdev_rx_phy: RTL and testbench

- Parametrised oversampling USB receive front end for the usbdev design.
- Takes synchronised D+/D- line samples; recovers bit timing from transitions; detects SYNC; NRZI-decodes and unstuffs; emits a byte stream with active, valid, EOP and error strobes.
- Sits between the pad synchronisers and the packet/PID decoder.
- Generalises the fixed full-speed receiver to any oversample ratio, either bus speed, and a configurable SYNC tolerance.

---
 rtl/usbdev_rx_phy.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_usbdev_rx_phy.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbdev_rx_phy.sv
// usbdev_rx_phy: oversampling USB receive front end.
// Recovers bit timing from line transitions, detects SYNC, NRZI-decodes and
// unstuffs the bit stream, and delivers bytes LSB-first with active, valid,
// EOP and error strobes. Works at either bus speed and any oversample ratio
// of 3 or more.
// Optional feature: define USBDEV_RX_CRC16_EN to add the CRC16 check that
// drives rx_crc_ok_o. Without it rx_crc_ok_o is tied low.

module usbdev_rx_phy #(
    parameter int unsigned OVERSAMPLE     = 4,
    parameter int unsigned SYNC_MIN_ZEROS = 5,
    parameter bit          LOW_SPEED      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       dp_i,
    input  logic       dn_i,
    output logic       rx_active_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_eop_o,
    output logic       rx_err_o,
    output logic [1:0] rx_err_code_o,
    output logic       rx_crc_ok_o
);

    if (OVERSAMPLE < 3) begin : gBadOversample
        $error("usbdev_rx_phy: OVERSAMPLE must be 3 or more");
    end
    if ((SYNC_MIN_ZEROS < 1) || (SYNC_MIN_ZEROS > 7)) begin : gBadSyncMinZeros
        $error("usbdev_rx_phy: SYNC_MIN_ZEROS must be in 1..7");
    end

    localparam int unsigned PW = (OVERSAMPLE < 3) ? 2 : $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] LAST_PHASE   = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PHASE_ONE    = PW'(1);
    localparam logic [2:0]    MIN_ZEROS    = 3'(SYNC_MIN_ZEROS);

    // Line states as {dp, dn}
    localparam logic [1:0] LINE_J   = LOW_SPEED ? 2'b01 : 2'b10;
    localparam logic [1:0] LINE_K   = LOW_SPEED ? 2'b10 : 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    localparam logic [1:0] ERR_STUFF   = 2'b01;
    localparam logic [1:0] ERR_PARTIAL = 2'b10;
    localparam logic [1:0] ERR_SE1     = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP   = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    logic [1:0]    lineNow;
    logic [1:0]    line_q;
    logic [PW-1:0] phase_q, phase_d, phaseNow;
    logic          sampleNow;
    logic [1:0]    samp_q, samp_d;
    logic          bitNow;
    logic          isJ, isK, isSe0, isSe1;

    logic [2:0] state_q, state_d;
    logic [2:0] zeroCnt_q, zeroCnt_d;
    logic [2:0] onesCnt_q, onesCnt_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic       se0Seen_q, se0Seen_d;
    logic       active_q, active_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       eop_q, eop_d;
    logic       err_q, err_d;
    logic [1:0] errCode_q, errCode_d;

`ifdef USBDEV_RX_CRC16_EN
    logic [15:0] crc_q, crc_d;
    logic [1:0]  byteCnt_q, byteCnt_d;
    logic        crcOk_q, crcOk_d;

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
        crcStep = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h8005 : 16'h0000);
    endfunction
`endif

    assign lineNow = {dp_i, dn_i};
    assign isJ     = (lineNow == LINE_J);
    assign isK     = (lineNow == LINE_K);
    assign isSe0   = (lineNow == LINE_SE0);
    assign isSe1   = (lineNow == LINE_SE1);

    // Bit timing: a transition restarts the phase so the sample lands mid-bit
    always_comb begin
        phaseNow  = (lineNow != line_q) ? '0 : phase_q;
        sampleNow = (phaseNow == SAMPLE_PHASE);
        phase_d   = (phaseNow == LAST_PHASE) ? '0 : phaseNow + PHASE_ONE;
        samp_d    = sampleNow ? lineNow : samp_q;
        bitNow    = (lineNow == samp_q);
    end

    // Receive state machine: SYNC hunt, unstuffing, byte assembly, EOP and abort handling
    always_comb begin
        state_d   = state_q;
        zeroCnt_d = zeroCnt_q;
        onesCnt_d = onesCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        se0Seen_d = se0Seen_q;
        active_d  = active_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        errCode_d = errCode_q;
`ifdef USBDEV_RX_CRC16_EN
        crc_d     = crc_q;
        byteCnt_d = byteCnt_q;
        crcOk_d   = crcOk_q;
`endif

        if (!enable_i) begin
            state_d   = ST_IDLE;
            active_d  = 1'b0;
            zeroCnt_d = 3'd0;
            onesCnt_d = 3'd0;
            bitCnt_d  = 3'd0;
            shift_d   = 8'h00;
            se0Seen_d = 1'b0;
        end else if (sampleNow) begin
            case (state_q)
                ST_IDLE: begin
                    if (isK) begin
                        state_d   = ST_SYNC;
                        zeroCnt_d = 3'd1;
                    end
                end

                ST_SYNC: begin
                    if (isSe1) begin
                        state_d   = ST_ABORT;
                        se0Seen_d = 1'b0;
                        active_d  = 1'b0;
                        err_d     = 1'b1;
                        errCode_d = ERR_SE1;
                    end else if (isSe0) begin
                        state_d = ST_IDLE;
                    end else if (bitNow) begin
                        if (zeroCnt_q >= MIN_ZEROS) begin
                            state_d   = ST_DATA;
                            active_d  = 1'b1;
                            onesCnt_d = 3'd0;
                            bitCnt_d  = 3'd0;
                            shift_d   = 8'h00;
`ifdef USBDEV_RX_CRC16_EN
                            crc_d     = 16'hFFFF;
                            byteCnt_d = 2'd0;
                            crcOk_d   = 1'b0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (zeroCnt_q != 3'd7) begin
                        zeroCnt_d = zeroCnt_q + 3'd1;
                    end
                end

                ST_DATA: begin
                    if (isSe1) begin
                        state_d   = ST_ABORT;
                        se0Seen_d = 1'b0;
                        active_d  = 1'b0;
                        err_d     = 1'b1;
                        errCode_d = ERR_SE1;
                    end else if (isSe0) begin
                        state_d = ST_EOP;
                    end else if (onesCnt_q == 3'd6) begin
                        if (bitNow) begin
                            state_d   = ST_ABORT;
                            se0Seen_d = 1'b0;
                            active_d  = 1'b0;
                            err_d     = 1'b1;
                            errCode_d = ERR_STUFF;
                        end else begin
                            onesCnt_d = 3'd0;
                        end
                    end else begin
                        shift_d   = {bitNow, shift_q[7:1]};
                        bitCnt_d  = bitCnt_q + 3'd1;
                        onesCnt_d = bitNow ? onesCnt_q + 3'd1 : 3'd0;
                        if (bitCnt_q == 3'd7) begin
                            valid_d = 1'b1;
                            data_d  = {bitNow, shift_q[7:1]};
                        end
`ifdef USBDEV_RX_CRC16_EN
                        if (byteCnt_q != 2'd0) begin
                            crc_d = crcStep(crc_q, bitNow);
                        end
                        if ((bitCnt_q == 3'd7) && (byteCnt_q != 2'd3)) begin
                            byteCnt_d = byteCnt_q + 2'd1;
                        end
`endif
                    end
                end

                ST_EOP: begin
                    if (isSe1) begin
                        state_d   = ST_ABORT;
                        se0Seen_d = 1'b0;
                        active_d  = 1'b0;
                        err_d     = 1'b1;
                        errCode_d = ERR_SE1;
                    end else if (isJ) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        eop_d    = 1'b1;
                        if (bitCnt_q != 3'd0) begin
                            err_d     = 1'b1;
                            errCode_d = ERR_PARTIAL;
                        end
`ifdef USBDEV_RX_CRC16_EN
                        crcOk_d = (crc_q == 16'h800D) && (byteCnt_q == 2'd3);
`endif
                    end
                end

                ST_ABORT: begin
                    if (isSe0) begin
                        se0Seen_d = 1'b1;
                    end else if (isJ && se0Seen_q) begin
                        state_d   = ST_IDLE;
                        se0Seen_d = 1'b0;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset restores an idle J line
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            line_q    <= LINE_J;
            phase_q   <= '0;
            samp_q    <= LINE_J;
            state_q   <= ST_IDLE;
            zeroCnt_q <= 3'd0;
            onesCnt_q <= 3'd0;
            bitCnt_q  <= 3'd0;
            shift_q   <= 8'h00;
            se0Seen_q <= 1'b0;
            active_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= 2'b00;
`ifdef USBDEV_RX_CRC16_EN
            crc_q     <= 16'hFFFF;
            byteCnt_q <= 2'd0;
            crcOk_q   <= 1'b0;
`endif
        end else begin
            line_q    <= lineNow;
            phase_q   <= phase_d;
            samp_q    <= samp_d;
            state_q   <= state_d;
            zeroCnt_q <= zeroCnt_d;
            onesCnt_q <= onesCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            se0Seen_q <= se0Seen_d;
            active_q  <= active_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
`ifdef USBDEV_RX_CRC16_EN
            crc_q     <= crc_d;
            byteCnt_q <= byteCnt_d;
            crcOk_q   <= crcOk_d;
`endif
        end
    end

    assign rx_active_o   = active_q;
    assign rx_valid_o    = valid_q;
    assign rx_data_o     = data_q;
    assign rx_eop_o      = eop_q;
    assign rx_err_o      = err_q;
    assign rx_err_code_o = errCode_q;
`ifdef USBDEV_RX_CRC16_EN
    assign rx_crc_ok_o   = crcOk_q;
`else
    assign rx_crc_ok_o   = 1'b0;
`endif

endmodule

// File: tb/tb_usbdev_rx_phy.sv
// tb_usbdev_rx_phy: drives NRZI-encoded, bit-stuffed USB packets into two
// receivers (full-speed x4 and low-speed x8 with edge jitter) and compares
// the delivered bytes and strobes against what the transmitted packet implies.

module tb_usbdev_rx_phy;

    localparam int OS_A = 4;
    localparam int OS_B = 8;
    localparam int SJ = 0;
    localparam int SK = 1;
    localparam int S0 = 2;
    localparam int S1 = 3;

`ifdef USBDEV_RX_CRC16_EN
    localparam int EXP_CRC_GOOD = 1;
`else
    localparam int EXP_CRC_GOOD = 0;
`endif

    logic       clk;
    logic       rstN;
    logic       enable;
    logic       dpA, dnA, dpB, dnB;
    logic       rxActiveA, rxValidA, rxEopA, rxErrA, rxCrcOkA;
    logic [7:0] rxDataA;
    logic [1:0] rxErrCodeA;
    logic       rxActiveB, rxValidB, rxEopB, rxErrB, rxCrcOkB;
    logic [7:0] rxDataB;
    logic [1:0] rxErrCodeB;

    int nCompared;
    int nMismatched;

    logic [7:0] gotA[$];
    logic [7:0] gotB[$];
    int eopA, errA, codeA, activeA, overlapA, errActiveA, eopErrA, crcA;
    int eopB, errB, codeB, activeB, overlapB, errActiveB;

    int symQ[$];
    bit bitQ[$];
    int onesRun;

    usbdev_rx_phy #(.OVERSAMPLE(OS_A), .SYNC_MIN_ZEROS(5), .LOW_SPEED(1'b0)) dutA (
        .clk_i(clk), .rst_ni(rstN), .enable_i(enable), .dp_i(dpA), .dn_i(dnA),
        .rx_active_o(rxActiveA), .rx_valid_o(rxValidA), .rx_data_o(rxDataA),
        .rx_eop_o(rxEopA), .rx_err_o(rxErrA), .rx_err_code_o(rxErrCodeA),
        .rx_crc_ok_o(rxCrcOkA)
    );

    usbdev_rx_phy #(.OVERSAMPLE(OS_B), .SYNC_MIN_ZEROS(5), .LOW_SPEED(1'b1)) dutB (
        .clk_i(clk), .rst_ni(rstN), .enable_i(enable), .dp_i(dpB), .dn_i(dnB),
        .rx_active_o(rxActiveB), .rx_valid_o(rxValidB), .rx_data_o(rxDataB),
        .rx_eop_o(rxEopB), .rx_err_o(rxErrB), .rx_err_code_o(rxErrCodeB),
        .rx_crc_ok_o(rxCrcOkB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard collection on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rxValidA) gotA.push_back(rxDataA);
        if (rxEopA) begin eopA++; crcA = int'(rxCrcOkA); end
        if (rxErrA) begin errA++; codeA = int'(rxErrCodeA); end
        if (rxValidA && rxEopA) overlapA++;
        if (rxErrA && rxActiveA) errActiveA++;
        if (rxEopA && rxErrA) eopErrA++;
        if (rxActiveA) activeA++;
        if (rxValidB) gotB.push_back(rxDataB);
        if (rxEopB) eopB++;
        if (rxErrB) begin errB++; codeB = int'(rxErrCodeB); end
        if (rxValidB && rxEopB) overlapB++;
        if (rxErrB && rxActiveB) errActiveB++;
        if (rxActiveB) activeB++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearScore();
        gotA.delete(); gotB.delete();
        eopA = 0; errA = 0; codeA = 0; activeA = 0; overlapA = 0; errActiveA = 0; eopErrA = 0; crcA = 0;
        eopB = 0; errB = 0; codeB = 0; activeB = 0; overlapB = 0; errActiveB = 0;
    endtask

    function automatic logic [1:0] symToLine(input bit lowSpeed, input int s);
        case (s)
            SJ:      return lowSpeed ? 2'b01 : 2'b10;
            SK:      return lowSpeed ? 2'b10 : 2'b01;
            S0:      return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    task automatic driveLine(input int which, input int s);
        if (which == 0) {dpA, dnA} = symToLine(1'b0, s);
        else            {dpB, dnB} = symToLine(1'b1, s);
    endtask

    task automatic idle(input int cycles);
        driveLine(0, SJ);
        driveLine(1, SJ);
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    task automatic startBits();
        bitQ.delete();
        onesRun = 0;
    endtask

    // Transmitter side: append bits LSB-first, inserting a 0 after six 1s
    task automatic pushBits(input logic [7:0] value, input int n, input bit stuff);
        for (int i = 0; i < n; i++) begin
            bitQ.push_back(value[i]);
            if (value[i]) onesRun++;
            else onesRun = 0;
            if (stuff && onesRun == 6) begin
                bitQ.push_back(1'b0);
                onesRun = 0;
            end
        end
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it; SYNC KJKJKJKK leads the frame
    task automatic encodeFrame(input bit withEop);
        int cur;
        int syncPat[8];
        syncPat = '{SK, SJ, SK, SJ, SK, SJ, SK, SK};
        symQ.delete();
        repeat (4) symQ.push_back(SJ);
        for (int i = 0; i < 8; i++) symQ.push_back(syncPat[i]);
        cur = SK;
        for (int i = 0; i < bitQ.size(); i++) begin
            if (bitQ[i] == 1'b0) cur = (cur == SJ) ? SK : SJ;
            symQ.push_back(cur);
        end
        if (withEop) begin
            symQ.push_back(S0);
            symQ.push_back(S0);
            repeat (5) symQ.push_back(SJ);
        end
    endtask

    task automatic applyStimulus(input int which, input int jitter, input int maxSyms);
        int os;
        int offPrev;
        int offNext;
        int dur;
        int last;
        os = (which == 0) ? OS_A : OS_B;
        offPrev = 0;
        last = (maxSyms < symQ.size()) ? maxSyms : symQ.size();
        for (int i = 0; i < last; i++) begin
            offNext = (jitter != 0 && i != last - 1) ? int'($urandom_range(2)) - 1 : 0;
            dur = os + offNext - offPrev;
            offPrev = offNext;
            driveLine(which, symQ[i]);
            repeat (dur) begin @(posedge clk); #1; end
        end
    endtask

    task automatic sendGood(input int which, input int jitter, input logic [7:0] bytes[$]);
        startBits();
        for (int i = 0; i < bytes.size(); i++) pushBits(bytes[i], 8, 1'b1);
        encodeFrame(1'b1);
        applyStimulus(which, jitter, symQ.size());
        idle(24);
    endtask

    task automatic checkBytes(input int which, input string tag, input logic [7:0] exp[$]);
        int n;
        n = (which == 0) ? gotA.size() : gotB.size();
        checkOutput({tag, "_count"}, n, exp.size());
        for (int i = 0; i < exp.size() && i < n; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (which == 0) ? int'(gotA[i]) : int'(gotB[i]), int'(exp[i]));
        end
    endtask

    initial begin
        logic [7:0] exp[$];
        int len;
        nCompared = 0;
        nMismatched = 0;
        clearScore();
        rstN = 1'b0;
        enable = 1'b1;
        driveLine(0, SJ);
        driveLine(1, SJ);
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] reset state");
        checkOutput("rst_activeA", rxActiveA, 0);
        checkOutput("rst_validA", rxValidA, 0);
        checkOutput("rst_dataA", rxDataA, 0);
        checkOutput("rst_eopA", rxEopA, 0);
        checkOutput("rst_errA", rxErrA, 0);
        checkOutput("rst_codeA", rxErrCodeA, 0);
        checkOutput("rst_crcA", rxCrcOkA, 0);
        checkOutput("rst_activeB", rxActiveB, 0);
        checkOutput("rst_validB", rxValidB, 0);
        checkOutput("rst_dataB", rxDataB, 0);
        checkOutput("rst_errB", rxErrB, 0);
        rstN = 1'b1;
        idle(40);

        $display("[TB] zero-length DATA0 packet");
        clearScore();
        exp = '{8'hC3, 8'h00, 8'h00};
        sendGood(0, 0, exp);
        checkBytes(0, "zlp", exp);
        checkOutput("zlp_eop", eopA, 1);
        checkOutput("zlp_err", errA, 0);
        checkOutput("zlp_overlap", overlapA, 0);
        checkOutput("zlp_crc", crcA, EXP_CRC_GOOD);
        checkOutput("zlp_active_seen", int'(activeA > 0), 1);
        checkOutput("zlp_active_end", rxActiveA, 0);

        $display("[TB] corrupted CRC packet");
        clearScore();
        exp = '{8'hC3, 8'h00, 8'h01};
        sendGood(0, 0, exp);
        checkBytes(0, "badcrc", exp);
        checkOutput("badcrc_eop", eopA, 1);
        checkOutput("badcrc_crc", crcA, 0);

        $display("[TB] stuffed 0xFF then 0x3F");
        clearScore();
        exp = '{8'hFF, 8'h3F};
        sendGood(0, 0, exp);
        checkBytes(0, "stuff", exp);
        checkOutput("stuff_eop", eopA, 1);
        checkOutput("stuff_err", errA, 0);

        $display("[TB] seven ones in DATA");
        clearScore();
        startBits();
        pushBits(8'hC3, 8, 1'b1);
        pushBits(8'h7F, 7, 1'b0);
        encodeFrame(1'b1);
        applyStimulus(0, 0, symQ.size());
        idle(24);
        exp = '{8'hC3};
        checkBytes(0, "stufferr", exp);
        checkOutput("stufferr_err", errA, 1);
        checkOutput("stufferr_code", codeA, 1);
        checkOutput("stufferr_eop", eopA, 0);
        checkOutput("stufferr_active_at_err", errActiveA, 0);

        $display("[TB] SE1 inside DATA");
        clearScore();
        startBits();
        pushBits(8'hC3, 8, 1'b1);
        encodeFrame(1'b0);
        symQ.push_back(S1);
        symQ.push_back(S0);
        symQ.push_back(S0);
        repeat (4) symQ.push_back(SJ);
        applyStimulus(0, 0, symQ.size());
        idle(24);
        checkOutput("se1_err", errA, 1);
        checkOutput("se1_code", codeA, 3);
        checkOutput("se1_eop", eopA, 0);
        checkOutput("se1_bytes", gotA.size(), 1);

        $display("[TB] short SYNC");
        clearScore();
        symQ = '{SJ, SJ, SJ, SJ, SK, SJ, SK, SK, SJ, SJ, SJ, SJ, SJ, SJ};
        applyStimulus(0, 0, symQ.size());
        idle(24);
        checkOutput("shortsync_active", activeA, 0);
        checkOutput("shortsync_valid", gotA.size(), 0);
        checkOutput("shortsync_strobes", eopA + errA, 0);

        $display("[TB] partial byte at EOP");
        clearScore();
        startBits();
        pushBits(8'hC3, 8, 1'b1);
        pushBits(8'h02, 2, 1'b1);
        encodeFrame(1'b1);
        applyStimulus(0, 0, symQ.size());
        idle(24);
        exp = '{8'hC3};
        checkBytes(0, "partial", exp);
        checkOutput("partial_eop", eopA, 1);
        checkOutput("partial_code", codeA, 2);
        checkOutput("partial_err_with_eop", eopErrA, 1);

        $display("[TB] enable dropped mid-packet");
        clearScore();
        startBits();
        pushBits(8'hC3, 8, 1'b1);
        pushBits(8'h05, 4, 1'b1);
        encodeFrame(1'b0);
        applyStimulus(0, 0, symQ.size());
        checkOutput("endrop_active_before", rxActiveA, 1);
        enable = 1'b0;
        driveLine(0, SJ);
        @(posedge clk); #1;
        checkOutput("endrop_active_after", rxActiveA, 0);
        idle(40);
        enable = 1'b1;
        idle(24);
        checkOutput("endrop_eop", eopA, 0);
        checkOutput("endrop_err", errA, 0);
        checkOutput("endrop_bytes", gotA.size(), 1);

        $display("[TB] low-speed x8 with edge jitter");
        for (int it = 0; it < 3; it++) begin
            clearScore();
            exp = '{8'h5A};
            exp.push_back(8'($urandom));
            exp.push_back(8'($urandom));
            sendGood(1, 1, exp);
            checkBytes(1, $sformatf("jitter%0d", it), exp);
            checkOutput($sformatf("jitter%0d_eop", it), eopB, 1);
            checkOutput($sformatf("jitter%0d_err", it), errB, 0);
            checkOutput($sformatf("jitter%0d_overlap", it), overlapB, 0);
        end

        $display("[TB] random full-speed packets");
        for (int it = 0; it < 4; it++) begin
            clearScore();
            exp.delete();
            len = 1 + int'($urandom_range(4));
            for (int i = 0; i < len; i++) exp.push_back(8'($urandom));
            sendGood(0, 0, exp);
            checkBytes(0, $sformatf("rand%0d", it), exp);
            checkOutput($sformatf("rand%0d_eop", it), eopA, 1);
            checkOutput($sformatf("rand%0d_err", it), errA, 0);
            checkOutput($sformatf("rand%0d_overlap", it), overlapA, 0);
        end

        $display("[TB] reset mid-packet");
        clearScore();
        startBits();
        pushBits(8'hA5, 8, 1'b1);
        encodeFrame(1'b1);
        applyStimulus(0, 0, 16);
        checkOutput("midrst_active_before", rxActiveA, 1);
        rstN = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_active", rxActiveA, 0);
        checkOutput("midrst_data", rxDataA, 0);
        rstN = 1'b1;
        idle(40);
        checkOutput("midrst_strobes", eopA + errA, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
